// File: rtl/raster_scan_ctrl.sv
// Raster scan sequencer for the SIFT front end: x/y counters, sync strobes,
// line/frame pulses and a valid/ready pixel handshake under host start/stop control.
module raster_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          continuous,
  input  logic          pix_ready,
  output logic          pix_valid,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          line_start,
  output logic          frame_start,
  output logic          frame_done,
  output logic          busy
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_VS_END = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic          stop_pend_q, stop_pend_d;
  logic [CW-1:0] x_d, y_d;
  logic          pix_valid_d, hsync_n_d, vsync_n_d;
  logic          line_start_d, frame_start_d, frame_done_d, busy_d;
  logic          advance;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
      x           <= '0;
      y           <= '0;
      pix_valid   <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      x           <= x_d;
      y           <= y_d;
      pix_valid   <= pix_valid_d;
      hsync_n     <= hsync_n_d;
      vsync_n     <= vsync_n_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
      frame_done  <= frame_done_d;
      busy        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stop_pend_d   = stop_pend_q;
    x_d           = x;
    y_d           = y;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    advance       = !(pix_valid && !pix_ready);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = RUN;
          stop_pend_d   = 1'b0;
          x_d           = '0;
          y_d           = '0;
          line_start_d  = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      RUN: begin
        // A stop arriving on the end-of-frame cycle must already count here.
        stop_pend_d = stop_pend_q | stop;
        if (advance) begin
          if (x == H_LAST) begin
            x_d          = '0;
            line_start_d = 1'b1;
            if (y == V_LAST) begin
              y_d          = '0;
              frame_done_d = 1'b1;
              if (!stop_pend_d && continuous) begin
                frame_start_d = 1'b1;
              end else begin
                state_d      = IDLE;
                stop_pend_d  = 1'b0;
                line_start_d = 1'b0;
              end
            end else begin
              y_d = y + CW'(1);
            end
          end else begin
            x_d = x + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Stalled cycles keep x/y, so these recompute to their held values.
    busy_d      = (state_d == RUN);
    pix_valid_d = busy_d && (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
    hsync_n_d   = !(busy_d && (32'(x_d) >= H_HS_BEG) && (32'(x_d) < H_HS_END));
    vsync_n_d   = !(busy_d && (32'(y_d) >= V_VS_BEG) && (32'(y_d) < V_VS_END));
  end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl with small timing; a linear-position reference model
// predicts every output each cycle under directed and randomized host/ready stimulus.
module tb_raster_scan_ctrl;

  localparam int unsigned HA = 4, HF = 1, HS = 1, HB = 2;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned TOT = HT * VT;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, continuous = 1'b0, pix_ready = 1'b1;
  logic          pix_valid, hsync_n, vsync_n, line_start, frame_start, frame_done, busy;
  logic [CW-1:0] x, y;

  raster_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CW(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .continuous(continuous), .pix_ready(pix_ready), .pix_valid(pix_valid),
    .x(x), .y(y), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .line_start(line_start), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: scan position as a single linear index into the frame.
  bit          m_run, m_sp, m_ls, m_fs, m_fd, m_clean;
  int unsigned m_pos, xfers;

  function automatic bit m_valid();
    return m_run && (m_pos % HT) < HA && (m_pos / HT) < VA;
  endfunction

  task automatic model_reset();
    m_run = 0; m_sp = 0; m_ls = 0; m_fs = 0; m_fd = 0; m_pos = 0;
    m_clean = 0; xfers = 0;
  endtask

  task automatic model_step();
    if (pix_valid && pix_ready) xfers++;
    if (m_run) begin
      bit stall;
      stall = m_valid() && !pix_ready;
      m_ls = 0; m_fs = 0; m_fd = 0;
      m_sp = m_sp | stop;
      if (!stall) begin
        if (m_pos == TOT - 1) begin
          m_fd = 1;
          m_pos = 0;
          if (!m_sp && continuous) begin
            m_fs = 1; m_ls = 1;
          end else begin
            m_run = 0; m_sp = 0;
          end
        end else begin
          m_pos++;
          m_ls = (m_pos % HT == 0);
        end
      end
    end else begin
      m_ls = 0; m_fs = 0; m_fd = 0;
      if (start) begin
        m_run = 1; m_pos = 0; m_fs = 1; m_ls = 1; m_sp = 0;
      end
    end
    if (m_fd && m_clean) check("xfers_per_frame", xfers, HA * VA);
    if (m_fs) begin
      xfers = 0; m_clean = 1;
    end
  endtask

  task automatic compare_all();
    int unsigned ex, ey;
    ex = m_pos % HT;
    ey = m_pos / HT;
    check("x", 32'(x), ex);
    check("y", 32'(y), ey);
    check("pix_valid", 32'(pix_valid), 32'(m_valid()));
    check("hsync_n", 32'(hsync_n), 32'(!(m_run && ex >= HA + HF && ex < HA + HF + HS)));
    check("vsync_n", 32'(vsync_n), 32'(!(m_run && ey >= VA + VF && ey < VA + VF + VS)));
    check("line_start", 32'(line_start), 32'(m_ls));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("busy", 32'(busy), 32'(m_run));
  endtask

  task automatic cyc(input logic st, input logic sp, input logic cn, input logic rd);
    start = st; stop = sp; continuous = cn; pix_ready = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to(input int unsigned p, input logic cn);
    int unsigned guard = 0;
    while (m_run && m_pos != p && guard < 200) begin
      cyc(1'b0, 1'b0, cn, 1'b1);
      guard++;
    end
    check("reach_pos", 32'(m_run && m_pos == p), 32'd1);
  endtask

  // Reset dropped mid-cycle must clear outputs before the next clock edge.
  task automatic async_reset();
    start = 0; stop = 0;
    @(posedge clk);
    model_step();
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
  endtask

  int unsigned fs_gap, fs_last, cyc_no;

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Single frame, always ready.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (52) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Stall three cycles on an active pixel.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    run_to(1 * HT + 2, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (50) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Continuous frames: frame_start spacing, then stop mid-frame.
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    fs_last = 0; cyc_no = 0;
    repeat (96) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc_no++;
      if (frame_start) begin
        check("frame_start_gap", cyc_no - fs_last, TOT);
        fs_last = cyc_no;
      end
    end
    run_to(2 * HT + 1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (60) cyc(1'b0, 1'b0, 1'b1, 1'b1);

    // start ignored in RUN; start+stop together in IDLE.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    run_to(3, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (50) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (50) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame, then restart.
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    run_to(4 * HT + 2, 1'b0);
    async_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (50) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // stop on the end-of-frame cycle with continuous set.
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    run_to(TOT - 1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (10) cyc(1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized host control, backpressure and occasional resets.
    repeat (4000) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 79) == 0),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
